mpeg_stream_ctrl: RTL and testbench

MPEG_STREAM_CTRL -- requirements
Module: mpeg_stream_ctrl

---
 rtl/mpeg_stream_ctrl_pkg.sv | 20 ++
 rtl/mpeg_stream_ctrl_pace.sv | 33 +++
 rtl/mpeg_stream_ctrl.sv | 148 ++++++++++++++
 tb/tb_mpeg_stream_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpeg_stream_ctrl_pkg.sv
// Shared types and widths for the MPEG stream controller.
// Holds the FSM encoding and counter sizing used by the top and pacer.
package mpeg_ctrl_pkg;

    localparam int CNT_W  = 32;
    localparam int PACE_W = 7;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FEED,
        ST_END,
        ST_DONE
    } state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/mpeg_stream_ctrl_pace.sv
// Byte pacer: counts 0..div while enabled, ticks on the last count.
// Held at zero outside the feed phase so every stream starts aligned.
module mpeg_pace_gen
    import mpeg_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [PACE_W-1:0] div,
    output logic              tick
);

    logic [PACE_W-1:0] cnt_q;
    logic [PACE_W-1:0] cnt_d;

    assign tick = en & (cnt_q == div);

    always_comb begin
        cnt_d = '0;
        if (en && !tick) begin
            cnt_d = cnt_q + PACE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mpeg_stream_ctrl.sv
// MPEG stream controller: paces source bytes into the datapath and
// drains the egress FIFO to the sink until the stream length is met.
module mpeg_stream_ctrl
    import mpeg_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  total_len,
    input  logic [PACE_W-1:0] pace_div,
    input  logic [DATA_W-1:0] src_data,
    input  logic              src_valid,
    output logic              src_ready,
    output logic [DATA_W-1:0] mpeg_in,
    output logic              mpeg_in_en,
    output logic              stream_end,
    input  logic              mpeg_prog_full,
    input  logic [DATA_W-1:0] mpeg_out,
    input  logic              mpeg_empty,
    output logic              mpeg_rd,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  in_cnt,
    output logic [CNT_W-1:0]  out_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    state_e            state_q;
    logic [CNT_W-1:0]  len_q;
    logic [PACE_W-1:0] pace_q;
    logic [CNT_W-1:0]  in_cnt_q;
    logic [CNT_W-1:0]  out_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [DATA_W-1:0] mpeg_in_q;
    logic              mpeg_in_en_q;
    logic              stream_end_q;
    logic              out_valid_q;
    logic              done_q;

    logic in_feed;
    logic in_end;
    logic pace_tick;
    logic xfer;
    logic rd_limit;

    assign in_feed = (state_q == ST_FEED);
    assign in_end  = (state_q == ST_END);

    mpeg_pace_gen u_pace (
        .clk  (clk),
        .rst  (rst),
        .en   (in_feed),
        .div  (pace_q),
        .tick (pace_tick)
    );

    assign src_ready = in_feed & pace_tick & ~mpeg_prog_full
                     & (in_cnt_q < len_q);
    assign xfer      = src_ready & src_valid;

    // A read already in flight counts toward the length, so no overread.
    assign rd_limit  = ((out_cnt_q + CNT_W'(out_valid_q)) == len_q);
    assign mpeg_rd   = ~mpeg_empty & (in_feed | in_end) & ~rd_limit;

    assign mpeg_in    = mpeg_in_q;
    assign mpeg_in_en = mpeg_in_en_q;
    assign stream_end = stream_end_q;
    assign out_data   = mpeg_out;
    assign out_valid  = out_valid_q;
    assign busy       = in_feed | in_end;
    assign done       = done_q;
    assign in_cnt     = in_cnt_q;
    assign out_cnt    = out_cnt_q;
    assign stall_cnt  = stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            pace_q       <= '0;
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
            stall_cnt_q  <= '0;
            mpeg_in_q    <= '0;
            mpeg_in_en_q <= 1'b0;
            stream_end_q <= 1'b0;
            out_valid_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            mpeg_in_en_q <= 1'b0;
            done_q       <= 1'b0;
            out_valid_q  <= mpeg_rd;
            if (abort) begin
                state_q      <= ST_IDLE;
                stream_end_q <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            len_q        <= total_len;
                            pace_q       <= pace_div;
                            in_cnt_q     <= '0;
                            out_cnt_q    <= '0;
                            stall_cnt_q  <= '0;
                            stream_end_q <= (total_len == '0);
                            state_q      <= (total_len == '0) ? ST_END
                                                              : ST_FEED;
                        end
                    end
                    ST_FEED: begin
                        if (xfer) begin
                            mpeg_in_q    <= src_data;
                            mpeg_in_en_q <= 1'b1;
                            in_cnt_q     <= in_cnt_q + CNT_W'(1);
                        end
                        if (mpeg_prog_full) begin
                            stall_cnt_q <= sat_inc(stall_cnt_q);
                        end
                        if (out_valid_q) begin
                            out_cnt_q <= out_cnt_q + CNT_W'(1);
                        end
                        if (in_cnt_q == len_q) begin
                            state_q      <= ST_END;
                            stream_end_q <= 1'b1;
                        end
                    end
                    ST_END: begin
                        if (out_valid_q) begin
                            out_cnt_q <= out_cnt_q + CNT_W'(1);
                        end
                        if (out_cnt_q == len_q) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        state_q      <= ST_IDLE;
                        stream_end_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mpeg_stream_ctrl.sv
// Testbench for mpeg_stream_ctrl with a loopback FIFO on the datapath.
// Table of stream scenarios plus directed abort/zero-length/reset cases.
module tb_mpeg_stream_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] total_len = '0;
    logic [6:0]  pace_div = '0;
    logic [7:0]  src_data;
    logic        src_valid = 1'b1;
    logic        src_ready;
    logic [7:0]  mpeg_in;
    logic        mpeg_in_en;
    logic        stream_end;
    logic        mpeg_prog_full = 1'b0;
    logic [7:0]  mpeg_out;
    logic        mpeg_empty;
    logic        mpeg_rd;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        busy;
    logic        done;
    logic [31:0] in_cnt;
    logic [31:0] out_cnt;
    logic [31:0] stall_cnt;

    mpeg_stream_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .total_len      (total_len),
        .pace_div       (pace_div),
        .src_data       (src_data),
        .src_valid      (src_valid),
        .src_ready      (src_ready),
        .mpeg_in        (mpeg_in),
        .mpeg_in_en     (mpeg_in_en),
        .stream_end     (stream_end),
        .mpeg_prog_full (mpeg_prog_full),
        .mpeg_out       (mpeg_out),
        .mpeg_empty     (mpeg_empty),
        .mpeg_rd        (mpeg_rd),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .busy           (busy),
        .done           (done),
        .in_cnt         (in_cnt),
        .out_cnt        (out_cnt),
        .stall_cnt      (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        int pace;
        int flo;
        int fhi;
        int seed;
        int exp_in;
        int exp_out;
        int exp_stall;
        int exp_first;
        int exp_gap;
    } vec_t;

    vec_t vecs[5];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cyc0 = 0;
    int mk;
    int in_seen;
    int out_seen;
    int rd_seen;
    int done_seen;
    int se_k;
    int src_idx;
    logic [7:0] seed_b;
    int en_k[$];
    logic [7:0] fq[$];
    int fn;

    task automatic check(input string name, input longint act,
                         input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    assign src_data = seed_b + src_idx[7:0];

    always @(posedge clk) begin
        if (!rst && src_ready && src_valid) src_idx <= src_idx + 1;
    end

    // Loopback egress FIFO with a registered read port.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fq.delete();
            mpeg_out   <= 8'h00;
            mpeg_empty <= 1'b1;
        end else begin
            fn = fq.size();
            if (mpeg_rd && fn > 0) begin
                mpeg_out <= fq.pop_front();
                fn--;
            end
            if (mpeg_in_en) begin
                fq.push_back(mpeg_in);
                fn++;
            end
            mpeg_empty <= (fn == 0);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            mk = cyc - cyc0;
            if (mpeg_in_en) begin
                check("in_byte", mpeg_in, 8'(seed_b + 8'(in_seen)));
                in_seen++;
                en_k.push_back(mk);
            end
            if (out_valid && busy) begin
                check("out_byte", out_data, 8'(seed_b + 8'(out_seen)));
                out_seen++;
            end
            if (mpeg_rd) rd_seen++;
            if (done) done_seen++;
            if (stream_end && se_k < 0) se_k = mk;
        end
    end

    task automatic clear_mon();
        src_idx   = 0;
        in_seen   = 0;
        out_seen  = 0;
        rd_seen   = 0;
        done_seen = 0;
        se_k      = -1;
        en_k.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic start_stream(input int len, input int pace,
                                input int seed);
        seed_b    = 8'(seed);
        total_len = 32'(len);
        pace_div  = 7'(pace);
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc0 = cyc;
    endtask

    task automatic run_vec(input vec_t v);
        bit timed_out;
        int bad;
        do_reset();
        clear_mon();
        start_stream(v.len, v.pace, v.seed);
        timed_out = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            mpeg_prog_full = (k >= v.flo) && (k <= v.fhi);
            @(posedge clk);
            #1;
            if (done_seen != 0) begin
                timed_out = 1'b0;
                break;
            end
        end
        mpeg_prog_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("timeout", timed_out, 0);
        check("in_cnt", in_cnt, v.exp_in);
        check("out_cnt", out_cnt, v.exp_out);
        check("stall_cnt", stall_cnt, v.exp_stall);
        check("done_pulses", done_seen, 1);
        check("idle_busy", busy, 0);
        check("idle_end", stream_end, 0);
        check("en_pulses", en_k.size(), v.exp_in);
        check("out_bytes", out_seen, v.exp_out);
        if (en_k.size() > 0) begin
            check("first_en", en_k[0], v.exp_first);
            check("end_rise", se_k, en_k[en_k.size()-1] + 1);
        end
        if (v.exp_gap != 0) begin
            bad = 0;
            for (int i = 1; i < en_k.size(); i++) begin
                if (en_k[i] - en_k[i-1] != v.exp_gap) bad++;
            end
            check("gap", bad, 0);
        end
    endtask

    initial begin
        bit timed_out;
        vecs[0] = '{4,  3,   -1, -1, 'h10, 4,  4,  0,  4,   4};
        vecs[1] = '{8,  0,    3,  6, 'h40, 8,  8,  4,  1,   0};
        vecs[2] = '{16, 1,   -1, -1, 'hA0, 16, 16, 0,  2,   2};
        vecs[3] = '{5,  2,    0,  9, 'h20, 5,  5,  10, 12,  0};
        vecs[4] = '{3,  127, -1, -1, 'hF0, 3,  3,  0,  128, 128};

        clear_mon();
        seed_b = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_cnt", in_cnt, 0);
        check("rst_out_cnt", out_cnt, 0);
        check("rst_stall", stall_cnt, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_end", stream_end, 0);
        check("rst_in_en", mpeg_in_en, 0);
        check("rst_in", mpeg_in, 0);
        check("rst_ovalid", out_valid, 0);
        check("rst_ready", src_ready, 0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // zero-length stream
        do_reset();
        clear_mon();
        start_stream(0, 5, 'h00);
        check("z_end", stream_end, 1);
        check("z_busy", busy, 1);
        check("z_done0", done, 0);
        @(posedge clk);
        #1;
        check("z_done1", done, 1);
        @(posedge clk);
        #1;
        check("z_done2", done, 0);
        check("z_idle", busy, 0);
        check("z_end2", stream_end, 0);
        check("z_en", en_k.size(), 0);
        check("z_rd", rd_seen, 0);
        check("z_pulses", done_seen, 1);

        // abort after half the stream
        do_reset();
        clear_mon();
        start_stream(10, 1, 'h55);
        timed_out = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            #1;
            if (in_cnt == 5) begin
                timed_out = 1'b0;
                break;
            end
        end
        check("ab_timeout", timed_out, 0);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("ab_busy", busy, 0);
        check("ab_in_en", mpeg_in_en, 0);
        check("ab_in_cnt", in_cnt, 5);
        repeat (20) @(posedge clk);
        #1;
        check("ab_hold", in_cnt, 5);
        check("ab_en", en_k.size(), 5);
        check("ab_done", done_seen, 0);
        check("ab_end", stream_end, 0);

        // start and abort together: abort wins
        total_len = 32'd7;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        check("sa_busy", busy, 0);
        check("sa_in_cnt", in_cnt, 5);

        // reset in the middle of feeding, then a full restart
        do_reset();
        clear_mon();
        start_stream(6, 0, 'h80);
        repeat (3) @(posedge clk);
        #1;
        check("mr_pre", in_cnt, 3);
        rst = 1'b1;
        #1;
        check("mr_in_cnt", in_cnt, 0);
        check("mr_in_en", mpeg_in_en, 0);
        check("mr_busy", busy, 0);
        check("mr_end", stream_end, 0);
        check("mr_ovalid", out_valid, 0);
        check("mr_ready", src_ready, 0);
        run_vec('{6, 0, -1, -1, 'h80, 6, 6, 0, 1, 1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
